// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice: controller FSM
// states and EX-stage forward-select encodings.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2
  } ctrlState_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage operand forward select for one source register; the memory-stage
// producer is newer than writeback, so it wins when both match.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] Forward
);

  always_comb begin
    Forward = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == RsE))
      Forward = FWD_MEM;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE))
      Forward = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: boot hold, prioritised stall/flush generation,
// operand forwarding, data-memory watchdog and stall/flush counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        ResultSrcE0,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        dmem_ready,
  input  logic        imem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam ctrlState_e RESET_STATE = (BOOT_CYCLES > 0) ? BOOT : RUN;

  ctrlState_e        state;
  ctrlState_e        nextState;
  logic [BOOT_W-1:0] bootCnt;
  logic [WAIT_W-1:0] waitCnt;
  logic              inBoot;
  logic              freeze;
  logic              loadUse;
  logic              redirect;

  assign inBoot   = (state == BOOT);
  assign freeze   = MemReqM & ~dmem_ready;
  assign loadUse  = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  // A branch held under a freeze does not count until it actually redirects.
  assign redirect = ~inBoot & ~freeze & PCSrcE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      BOOT:    if (bootCnt == BOOT_LAST) nextState = RUN;
      RUN:     if (freeze)               nextState = MWAIT;
      MWAIT:   if (!freeze)              nextState = RUN;
      default:                           nextState = RUN;
    endcase
  end

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst || inBoot) begin
      if (BOOT_CYCLES > 0) begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (loadUse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (!imem_ready) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  // waitCnt saturates so a long stall cannot wrap back below the threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bootCnt     <= '0;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (inBoot) bootCnt <= bootCnt + 1'b1;
      if (!inBoot && freeze) begin
        if (waitCnt != WAIT_MAX) waitCnt <= waitCnt + 1'b1;
        if (int'(waitCnt) + 1 >= MEM_TIMEOUT) mem_timeout <= 1'b1;
      end else begin
        waitCnt <= '0;
      end
      if (!inBoot && StallF) stall_cnt <= stall_cnt + 32'd1;
      if (redirect)          flush_cnt <= flush_cnt + 32'd1;
    end
  end

  fwd_sel u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardBE)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected control vectors are queued as
// stimulus is applied and popped when the outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       sF, sD, sE, sM, fD, fE, fW;
    logic [1:0] fa, fb;
  } ctrl_t;

  localparam ctrl_t C_IDLE = '0;
  localparam ctrl_t C_BOOT = {7'b1000110, 4'b0000};
  localparam ctrl_t C_LU   = {7'b1100010, 4'b0000};
  localparam ctrl_t C_RED  = {7'b0000110, 4'b0000};
  localparam ctrl_t C_IMEM = {7'b1000100, 4'b0000};
  localparam ctrl_t C_FRZ  = {7'b1111001, 4'b0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready, imem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  ctrl_t expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    failures = 0;
  int    expStall = 0;
  int    expFlush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.BOOT_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic ctrl_t fwd(input ctrl_t base, input logic [1:0] fa, input logic [1:0] fb);
    ctrl_t r;
    r = base;
    r.fa = fa;
    r.fb = fb;
    return r;
  endfunction

  task automatic set_idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0;
    dmem_ready = 1; imem_ready = 1;
  endtask

  task automatic push(input ctrl_t e, input string n);
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  // Waits for the falling edge, then returns the oldest expectation and the live outputs.
  task automatic sample(output ctrl_t e, output ctrl_t o, output string n);
    @(negedge clk);
    o = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
    e = expQ.pop_front();
    n = nameQ.pop_front();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ctrl_t e, o;
    string n;
    rst = 1;
    set_idle();
    next_cycle();
    push(C_BOOT, "reset_ctrl");
    sample(e, o, n);
    checks++;
    if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
    checks++;
    if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++;
    if (flush_cnt !== 32'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
    checks++;
    if (mem_timeout !== 1'b0) begin failures++; $display("FAIL reset_mem_timeout got=%b exp=0", mem_timeout); end
    next_cycle();
    rst = 0;
  endtask

  task automatic test_boot();
    ctrl_t e, o;
    string n;
    push(C_BOOT, "boot_c0");
    push(C_BOOT, "boot_c1");
    push(C_IDLE, "boot_run");
    for (int i = 0; i < 3; i++) begin
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
    end
    checks++;
    if (stall_cnt !== 32'd0) begin failures++; $display("FAIL boot_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_forwarding();
    ctrl_t e, o;
    string n;
    for (int i = 0; i < 4; i++) begin
      set_idle();
      case (i)
        0: begin RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 7;
                 push(fwd(C_IDLE, 2'b10, 2'b10), "fwd_mem_wins"); end
        1: begin RdM = 7; RdW = 7; RegWriteM = 0; RegWriteW = 1; Rs1E = 7; Rs2E = 7;
                 push(fwd(C_IDLE, 2'b01, 2'b01), "fwd_wb"); end
        2: begin RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; Rs1E = 0; Rs2E = 0;
                 push(fwd(C_IDLE, 2'b00, 2'b00), "fwd_x0"); end
        default: begin RdM = 7; RdW = 3; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 3;
                 push(fwd(C_IDLE, 2'b10, 2'b01), "fwd_split"); end
      endcase
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_load_use();
    ctrl_t e, o;
    string n;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      case (i)
        0: begin ResultSrcE0 = 1; RdE = 5; Rs1D = 5; push(C_LU, "lu_rs1"); expStall++; end
        1: begin ResultSrcE0 = 0; RdE = 5; Rs1D = 5; push(C_IDLE, "lu_one_bubble"); end
        2: begin ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0; push(C_IDLE, "lu_rd_x0"); end
        3: begin ResultSrcE0 = 1; RdE = 9; Rs1D = 1; Rs2D = 9; push(C_LU, "lu_rs2"); expStall++; end
        default: begin ResultSrcE0 = 1; RdE = 9; Rs1D = 1; Rs2D = 2; push(C_IDLE, "lu_no_match"); end
      endcase
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
    end
    set_idle();
    checks++;
    if (stall_cnt !== 32'(expStall)) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, expStall); end
  endtask

  task automatic test_redirect();
    ctrl_t e, o;
    string n;
    for (int i = 0; i < 4; i++) begin
      set_idle();
      case (i)
        0: begin PCSrcE = 1; ResultSrcE0 = 1; RdE = 5; Rs1D = 5; imem_ready = 0;
                 push(C_RED, "red_beats_all"); expFlush++; end
        1: begin imem_ready = 0; push(C_IMEM, "imem_wait"); expStall++; end
        2: begin PCSrcE = 1; push(C_RED, "red_alone"); expFlush++; end
        default: push(C_IDLE, "red_idle");
      endcase
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
    end
    set_idle();
    checks++;
    if (flush_cnt !== 32'(expFlush)) begin failures++; $display("FAIL red_flush_cnt got=%0d exp=%0d", flush_cnt, expFlush); end
    checks++;
    if (stall_cnt !== 32'(expStall)) begin failures++; $display("FAIL red_stall_cnt got=%0d exp=%0d", stall_cnt, expStall); end
  endtask

  task automatic test_freeze_branch();
    ctrl_t e, o;
    string n;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      if (i < 3) begin
        MemReqM = 1; dmem_ready = 0; PCSrcE = 1;
        push(C_FRZ, "frz_hold_branch"); expStall++;
      end else if (i == 3) begin
        MemReqM = 1; dmem_ready = 1; PCSrcE = 1;
        push(C_RED, "frz_then_redirect"); expFlush++;
      end else begin
        push(C_IDLE, "frz_idle");
      end
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
    end
    set_idle();
    checks++;
    if (mem_timeout !== 1'b0) begin failures++; $display("FAIL frz_no_timeout got=%b exp=0", mem_timeout); end
    checks++;
    if (flush_cnt !== 32'(expFlush)) begin failures++; $display("FAIL frz_flush_cnt got=%0d exp=%0d", flush_cnt, expFlush); end
    checks++;
    if (stall_cnt !== 32'(expStall)) begin failures++; $display("FAIL frz_stall_cnt got=%0d exp=%0d", stall_cnt, expStall); end
  endtask

  task automatic test_watchdog();
    ctrl_t e, o;
    string n;
    logic  expTo;
    for (int i = 0; i < 7; i++) begin
      set_idle();
      if (i < 5) begin
        MemReqM = 1; dmem_ready = 0;
        push(C_FRZ, "wd_freeze"); expStall++;
      end else begin
        push(C_IDLE, "wd_released");
      end
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
      expTo = (i >= 3);
      checks++;
      if (mem_timeout !== expTo) begin failures++; $display("FAIL wd_flag[%0d] got=%b exp=%b", i, mem_timeout, expTo); end
    end
    set_idle();
    checks++;
    if (stall_cnt !== 32'(expStall)) begin failures++; $display("FAIL wd_stall_cnt got=%0d exp=%0d", stall_cnt, expStall); end
  endtask

  task automatic test_reset_abort();
    ctrl_t e, o;
    string n;
    // Two freeze cycles, then reset lands in the middle of the wait.
    for (int i = 0; i < 3; i++) begin
      set_idle();
      MemReqM = 1; dmem_ready = 0;
      rst = (i == 2);
      push((i == 2) ? C_BOOT : C_FRZ, (i == 2) ? "abort_rst" : "abort_freeze");
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
    end
    rst = 0;
    expStall = 0;
    expFlush = 0;
    checks++;
    if (mem_timeout !== 1'b0) begin failures++; $display("FAIL abort_timeout_clr got=%b exp=0", mem_timeout); end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL abort_cnt_clr got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    // Boot again with forwarding active, then a fresh wait that must not trip the watchdog.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (i < 2) begin
        RdM = 7; RegWriteM = 1; Rs1E = 7;
        push(fwd(C_BOOT, 2'b10, 2'b00), "abort_boot_fwd");
      end else if (i < 5) begin
        MemReqM = 1; dmem_ready = 0;
        push(C_FRZ, "abort_new_wait"); expStall++;
      end else begin
        push(C_IDLE, "abort_idle");
      end
      sample(e, o, n);
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, o, e); end
      next_cycle();
    end
    set_idle();
    checks++;
    if (mem_timeout !== 1'b0) begin failures++; $display("FAIL abort_wait_cleared got=%b exp=0", mem_timeout); end
    checks++;
    if (stall_cnt !== 32'(expStall)) begin failures++; $display("FAIL abort_stall_cnt got=%0d exp=%0d", stall_cnt, expStall); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_freeze_branch();
    test_watchdog();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout reached time limit");
    $fatal(1, "time limit");
  end

endmodule
